// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction-fetch stage for the RV32I pipeline. It contains the PC generator,
// a synchronous instruction-memory request port and a DEPTH-entry circular
// {PC, instruction} prefetch queue that the decode stage drains through a
// valid/stall handshake. A MEM-stage redirect flushes the queue and discards
// any fetch that is still in flight.
//
// Optional feature: define IF_QUEUE_BYPASS_EN to forward a response straight
// to the ID outputs when the queue is empty. This cuts fetch-to-ID latency
// from 2 cycles to 1. With the macro undefined, the ID outputs always come
// from the queue head.
//
// Ports
//   Clk_100MHz          in   clock
//   Reset_n             in   synchronous active-low reset
//   MEM_PC_source_sel   in   redirect request (1 = take MEM_PC_branch_dest)
//   MEM_PC_branch_dest  in   redirect target, word aligned internally
//   ID_PC_stall         in   decode not accepting this cycle
//   Imem_rd_en          out  fetch request this cycle
//   Imem_addr           out  fetch address (the PC register)
//   Imem_rd_data        in   instruction, valid 1 cycle after a request
//   ID_valid            out  queue head (or bypassed response) valid
//   ID_PC               out  PC of the head instruction
//   ID_Instruction      out  head instruction
//   ID_occupancy        out  number of queued entries
module if_fetch_queue #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int unsigned      PC_STEP  = 4
) (
   input  logic                         Clk_100MHz,
   input  logic                         Reset_n,
   input  logic                         MEM_PC_source_sel,
   input  logic [XLEN-1:0]              MEM_PC_branch_dest,
   input  logic                         ID_PC_stall,
   output logic                         Imem_rd_en,
   output logic [XLEN-1:0]              Imem_addr,
   input  logic [31:0]                  Imem_rd_data,
   output logic                         ID_valid,
   output logic [XLEN-1:0]              ID_PC,
   output logic [31:0]                  ID_Instruction,
   output logic [$clog2(DEPTH+1)-1:0]   ID_occupancy
);

   localparam int unsigned     CW       = $clog2(DEPTH+1);
   localparam int unsigned     PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH-1);
   localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

   logic [XLEN-1:0]  pc_q;
   logic [XLEN-1:0]  req_pc_q;
   logic             inflight_q;
   logic [CW-1:0]    count_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [XLEN-1:0]  q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];

   logic             redirect;
   logic             resp_ok;
   logic             head_valid;
   logic             bypass;
   logic             pop;
   logic             q_pop;
   logic             q_push;
   logic [CW:0]      demand;

   // Redirect targets are word aligned; the two low bits are dropped.
   logic             unused_dest_lsb;
   assign unused_dest_lsb = ^MEM_PC_branch_dest[1:0];

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign redirect   = MEM_PC_source_sel;
   assign resp_ok    = inflight_q & ~redirect;
   assign head_valid = (count_q != '0);

`ifdef IF_QUEUE_BYPASS_EN
   assign bypass = resp_ok & ~head_valid;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      ID_valid       = head_valid | bypass;
      ID_PC          = '0;
      ID_Instruction = '0;
      if (head_valid) begin
         ID_PC          = q_pc[rd_ptr_q];
         ID_Instruction = q_instr[rd_ptr_q];
      end else if (bypass) begin
         ID_PC          = req_pc_q;
         ID_Instruction = Imem_rd_data;
      end
   end

   assign pop    = ID_valid & ~ID_PC_stall;
   assign q_pop  = pop & head_valid;
   // A bypassed response that decode takes this cycle never enters the queue.
   assign q_push = resp_ok & ~(bypass & pop);

   // Entries held plus the one that may still arrive, less the one leaving now.
   // Keeping this below DEPTH guarantees room for every response.
   assign demand     = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign Imem_rd_en = Reset_n & ~redirect & (demand < (CW+1)'(DEPTH));
   assign Imem_addr  = pc_q;
   assign ID_occupancy = count_q;

   always_ff @(posedge Clk_100MHz) begin
      if (!Reset_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         inflight_q <= Imem_rd_en;
         if (Imem_rd_en) begin
            pc_q     <= pc_q + XLEN'(PC_STEP);
            req_pc_q <= pc_q;
         end
         if (redirect) begin
            pc_q     <= {MEM_PC_branch_dest[XLEN-1:2], 2'b00};
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (q_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (q_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({q_push, q_pop})
               2'b10:   count_q <= count_q + CW'(1);
               2'b01:   count_q <= count_q - CW'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   always_ff @(posedge Clk_100MHz) begin
      if (Reset_n && q_push) begin
         q_pc[wr_ptr_q]    <= req_pc_q;
         q_instr[wr_ptr_q] <= Imem_rd_data;
      end
   end

   overflow_chk: assert property (@(posedge Clk_100MHz) disable iff (!Reset_n)
      !(q_push && !q_pop && (count_q == FULL_CNT)));

endmodule
